// File: rtl/cla_pkg.sv
// Shared constants and group-lookahead helper for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int BLOCK_DEF  = 8;
  localparam int WIDTH_MIN  = 8;
  localparam int WIDTH_MAX  = 64;
  localparam int GROUPS_MAX = 8;

  function automatic bit width_legal(input int width, input int block);
    return (block == 4 || block == 8) && (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           ((width % block) == 0) && ((width / block) <= GROUPS_MAX);
  endfunction

  // Single-level group generate/propagate over the low n bits (n <= 8).
  function automatic logic [1:0] group_gp(input logic [7:0] g, input logic [7:0] p, input int n);
    logic gg;
    logic gp;
    logic term;
    gg   = 1'b0;
    gp   = 1'b1;
    term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        term = g[i];
        for (int k = i + 1; k < 8; k++) begin
          if (k < n) term = term & p[k];
        end
        gg = gg | term;
        gp = gp & p[i];
      end
    end
    return {gg, gp};
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: group G/P plus the carry into every bit from the group carry-in.
module cla_group
  import cla_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic [BLOCK-1:0] g_i,
  input  logic [BLOCK-1:0] p_i,
  input  logic             c_i,
  output logic             gg_o,
  output logic             gp_o,
  output logic [BLOCK-1:0] c_o
);

  logic term;

  always_comb begin
    {gg_o, gp_o} = group_gp(8'(g_i), 8'(p_i), BLOCK);
    c_o  = '0;
    term = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      term = c_i;
      for (int m = 0; m < i; m++) term = term & p_i[m];
      c_o[i] = term;
      for (int k = 0; k < i; k++) begin
        term = g_i[k];
        for (int m = k + 1; m < i; m++) term = term & p_i[m];
        c_o[i] = c_o[i] | term;
      end
    end
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage carry-lookahead add/subtract with valid/ready flow control.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / BLOCK;

  if (!width_legal(WIDTH, BLOCK)) begin : g_cfg_check
    $error("pipelined_cla_adder: illegal WIDTH/BLOCK combination");
  end

  logic             vld_p1_q, vld_p2_q;
  logic             s1_adv, accept;
  logic [WIDTH-1:0] beff_d, p_d, g_d;
  logic [NG-1:0]    gg_d, gp_d;
  logic [WIDTH-1:0] a_p1_q, beff_p1_q, p_p1_q;
  logic [NG-1:0]    gg_p1_q, gp_p1_q;
  logic             cin_p1_q;
  logic [WIDTH-1:0] g_s2, c_s2, sum_d;
  logic [NG:0]      cg;
  logic             acc, pp;
  logic [NG-1:0]    unused_gg, unused_gp;
  logic [WIDTH-1:0] sum_p2_q;
  logic             cout_p2_q, ovf_p2_q, zero_p2_q;

  assign s1_adv   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (s1_adv)   vld_p2_q <= vld_p1_q;
    end
  end

  // ---- S1: operand conditioning and per-group G/P ----
  always_comb begin
    beff_d = sub ? ~b : b;
    p_d    = a ^ beff_d;
    g_d    = a & beff_d;
    gg_d   = '0;
    gp_d   = '0;
    for (int j = 0; j < NG; j++) begin
      {gg_d[j], gp_d[j]} = group_gp(8'(g_d[j*BLOCK +: BLOCK]), 8'(p_d[j*BLOCK +: BLOCK]), BLOCK);
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      a_p1_q    <= a;
      beff_p1_q <= beff_d;
      p_p1_q    <= p_d;
      gg_p1_q   <= gg_d;
      gp_p1_q   <= gp_d;
      cin_p1_q  <= sub;
    end
  end

  // ---- S2: second-level lookahead, each group carry formed independently ----
  always_comb begin
    cg    = '0;
    cg[0] = cin_p1_q;
    acc   = 1'b0;
    pp    = 1'b1;
    for (int j = 0; j < NG; j++) begin
      acc = 1'b0;
      for (int k = 0; k <= j; k++) begin
        pp = gg_p1_q[k];
        for (int m = k + 1; m <= j; m++) pp = pp & gp_p1_q[m];
        acc = acc | pp;
      end
      pp = cin_p1_q;
      for (int m = 0; m <= j; m++) pp = pp & gp_p1_q[m];
      cg[j+1] = acc | pp;
    end
  end

  assign g_s2 = a_p1_q & beff_p1_q;

  // Group G/P are taken from the S1 registers; the instance copies are redundant here.
  for (genvar j = 0; j < NG; j++) begin : g_grp
    cla_group #(.BLOCK(BLOCK)) u_grp (
      .g_i  (g_s2[j*BLOCK +: BLOCK]),
      .p_i  (p_p1_q[j*BLOCK +: BLOCK]),
      .c_i  (cg[j]),
      .gg_o (unused_gg[j]),
      .gp_o (unused_gp[j]),
      .c_o  (c_s2[j*BLOCK +: BLOCK])
    );
  end

  assign sum_d = p_p1_q ^ c_s2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_p2_q  <= '0;
      cout_p2_q <= 1'b0;
      ovf_p2_q  <= 1'b0;
      zero_p2_q <= 1'b0;
    end else if (vld_p1_q && s1_adv) begin
      sum_p2_q  <= sum_d;
      cout_p2_q <= cg[NG];
      ovf_p2_q  <= c_s2[WIDTH-1] ^ cg[NG];
      zero_p2_q <= (sum_d == '0);
    end
  end

  assign out_valid = vld_p2_q;
  assign sum       = sum_p2_q;
  assign cout      = cout_p2_q;
  assign ovf       = ovf_p2_q;
  assign zero      = zero_p2_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench driving 16/4, 32/8 and 64/8 adders in lockstep against an arithmetic reference model.
module tb_pipelined_cla_adder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub_v = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] a_v = '0;
  logic [63:0] b_v = '0;

  logic        ir16, ov16, c16, o16, z16;
  logic [15:0] s16;
  logic        ir32, ov32, c32, o32, z32;
  logic [31:0] s32;
  logic        ir64, ov64, c64, o64, z64;
  logic [63:0] s64;

  always #5 clock = ~clock;

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a_v[15:0]), .b(b_v[15:0]), .sub(sub_v), .out_valid(ov16), .out_ready(out_ready),
    .sum(s16), .cout(c16), .ovf(o16), .zero(z16));

  pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir32),
    .a(a_v[31:0]), .b(b_v[31:0]), .sub(sub_v), .out_valid(ov32), .out_ready(out_ready),
    .sum(s32), .cout(c32), .ovf(o32), .zero(z32));

  pipelined_cla_adder #(.WIDTH(64), .BLOCK(8)) u_dut64 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir64),
    .a(a_v), .b(b_v), .sub(sub_v), .out_valid(ov64), .out_ready(out_ready),
    .sum(s64), .cout(c64), .ovf(o64), .zero(z64));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
  } beat_t;

  typedef struct {
    int          w;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] esum;
    logic        ec;
    logic        eo;
    logic        ez;
  } vec_t;

  beat_t q[$];
  beat_t mon_e;
  logic  held = 1'b0;
  logic [66:0] h16, h32, h64;

  // Reference: plain integer arithmetic on w-bit operands, result packed {sum, cout, ovf, zero}.
  function automatic logic [66:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input int w);
    logic [64:0] mask, ua, ub, us;
    logic signed [65:0] sa, sb, sr, lim;
    logic c, o;
    mask = (65'd1 << w) - 65'd1;
    ua   = {1'b0, a} & mask;
    ub   = {1'b0, b} & mask;
    sa   = $signed({1'b0, ua} << (66 - w)) >>> (66 - w);
    sb   = $signed({1'b0, ub} << (66 - w)) >>> (66 - w);
    if (!s) begin
      us = ua + ub;
      c  = (us > mask);
      sr = sa + sb;
    end else begin
      us = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    us  = us & mask;
    lim = 66'sd1 <<< (w - 1);
    o   = (sr >= lim) || (sr < -lim);
    return {us[63:0], c, o, (us == 65'd0)};
  endfunction

  function automatic logic [66:0] act_of(input int w);
    if (w == 16) return {48'd0, s16, c16, o16, z16};
    if (w == 32) return {32'd0, s32, c32, o32, z32};
    return {s64, c64, o64, z64};
  endfunction

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_beat();
    a_v   = {$urandom, $urandom};
    b_v   = {$urandom, $urandom};
    sub_v = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || ov32) && n < 20) begin
      step();
      n++;
    end
    chk(name, 67'(q.size()), 67'd0);
  endtask

  // Scoreboard: the negedge view shows what the next rising edge will transfer.
  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      held = 1'b0;
    end else begin
      chk("ctl_agree", 67'({ir16, ov16, ir64, ov64}), 67'({ir32, ov32, ir32, ov32}));
      if (held) begin
        chk("hold_vld", 67'(ov32), 67'd1);
        chk("hold16", act_of(16), h16);
        chk("hold32", act_of(32), h32);
        chk("hold64", act_of(64), h64);
      end
      held = ov32 && !out_ready;
      h16  = act_of(16);
      h32  = act_of(32);
      h64  = act_of(64);
      if (ov32 && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out got=valid want=none");
        end else begin
          mon_e = q.pop_front();
          chk("sb16", act_of(16), model(mon_e.a, mon_e.b, mon_e.s, 16));
          chk("sb32", act_of(32), model(mon_e.a, mon_e.b, mon_e.s, 32));
          chk("sb64", act_of(64), model(mon_e.a, mon_e.b, mon_e.s, 64));
        end
      end
      if (in_valid && ir32) q.push_back('{a_v, b_v, sub_v});
    end
  end

  vec_t  tbl[12];
  int    bad;
  int    accepted;
  logic  took;
  beat_t z_beat;

  initial begin
    tbl[0]  = '{32, 64'hFFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{32, 64'h7FFF_FFFF, 64'h1, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32, 64'h5, 64'h7, 1'b1, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{32, 64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{32, 64'h8000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{32, 64'h5, 64'h5, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{32, 64'h8000_0000, 64'h8000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{16, 64'hFFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{16, 64'h7FFF, 64'h1, 1'b0, 64'h8000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{64, 64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{32, 64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};

    // Reset state, and beats offered during reset must be ignored.
    #2;
    chk("rst_vld", 67'({ov16, ov32, ov64}), 67'd0);
    chk("rst_ready", 67'({ir16, ir32, ir64}), 67'b111);
    chk("rst_out16", act_of(16), 67'd0);
    chk("rst_out32", act_of(32), 67'd0);
    chk("rst_out64", act_of(64), 67'd0);
    in_valid = 1'b1;
    rand_beat();
    step();
    step();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();
    step();
    step();
    chk("no_accept_in_rst", 67'(ov32), 67'd0);

    // Directed vectors with latency check.
    for (int i = 0; i < 12; i++) begin
      step();
      a_v = tbl[i].a;
      b_v = tbl[i].b;
      sub_v = tbl[i].s;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("lat_early", 67'(ov32), 67'd0);
      step();
      chk("lat_valid", 67'(ov32), 67'd1);
      chk($sformatf("vec%0d_w%0d", i, tbl[i].w), act_of(tbl[i].w),
          {tbl[i].esum, tbl[i].ec, tbl[i].eo, tbl[i].ez});
    end

    // 100 back-to-back beats: one result per cycle.
    bad = 0;
    for (int i = 0; i < 102; i++) begin
      step();
      if (i < 100) begin
        in_valid = 1'b1;
        rand_beat();
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
      if (i < 100 && !ir32) bad++;
      if (i >= 2 && !ov32) bad++;
    end
    chk("stream_rate", 67'(bad), 67'd0);
    drain("stream_drain");

    // Consumer stalled for 5 cycles: only two beats fit.
    accepted = 0;
    took = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      out_ready = 1'b0;
      in_valid = 1'b1;
      if (took) rand_beat();
      @(negedge clock);
      took = ir32;
      if (ir32) accepted++;
    end
    chk("stall_accepts", 67'(accepted), 67'd2);
    chk("stall_ready", 67'(ir32), 67'd0);
    step();
    drain("stall_drain");

    // Reset with both stages full.
    step();
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_beat();
    step();
    rand_beat();
    step();
    chk("full_before_rst", 67'({ov32, ir32}), 67'b10);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_vld", 67'({ov16, ov32, ov64}), 67'd0);
    chk("rst_mid_out32", act_of(32), 67'd0);
    chk("rst_mid_ready", 67'(ir32), 67'd1);
    step();
    step();
    reset_n = 1'b1;
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    in_valid = 1'b1;
    rand_beat();
    z_beat = '{a_v, b_v, sub_v};
    step();
    in_valid = 1'b0;
    step();
    chk("post_rst_vld", 67'(ov32), 67'd1);
    chk("post_rst_first", act_of(32), model(z_beat.a, z_beat.b, z_beat.s, 32));
    drain("post_rst_drain");

    // Random valid/ready pattern.
    took = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (took) rand_beat();
      @(negedge clock);
      took = in_valid && ir32;
    end
    step();
    drain("mixed_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
